array_loader: RTL and testbench

- Upstream feeder for the array sort-check stage.
- Accepts a valid/ready stream of 32-bit words and writes them into consecutive register-file entries starting at a given base.
- When the last word arrives, it hands `array` and `length` to the sort checker, pulses `go`, then waits for the checker's `done`.
- Captures the checker's `sorted` result and presents it with a one-cycle valid pulse.

---
 rtl/array_pkg.sv | 25 ++
 rtl/array_loader_counter.sv | 45 ++++
 rtl/array_loader.sv | 145 ++++++++++++++
 tb/tb_array_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// Shared definitions for the array loader: default widths, state encoding
// and width typedefs used by the loader top and its counter.
package array_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int MAX_LEN = 31;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [2:0]        state_t;

  // state   | meaning
  // IDLE    | waiting for start, result_sorted held
  // LOAD    | accepting stream words into the register file
  // GO      | single-cycle go pulse to the sort checker
  // WAIT    | waiting for the checker's done
  // ERR     | overflow seen, error held until the next start
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_GO   = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/array_loader_counter.sv
// Write-index bookkeeping for the loader: holds the captured base and the
// element count, and derives write address, length and the overflow compare.
module array_loader_counter #(
  parameter int ADDR_W  = 5,
  parameter int MAX_LEN = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              incr,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] base_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] len_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(MAX_LEN - 1);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] base_q;

  // Capture base and zero the count on start; step once per accepted beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
      base_q  <= '0;
    end else if (clear) begin
      count_q <= '0;
      base_q  <= base_i;
    end else if (incr) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Overflow means the current beat is the last one that may be stored,
  // either because the top index is reached or the array is full.
  always_comb begin
    wr_addr_o = base_q + count_q;
    len_o     = count_q + 1'b1;
    ovf_o     = (wr_addr_o == '1) || (count_q == LAST_CNT);
    base_o    = base_q;
  end

endmodule

// File: rtl/array_loader.sv
// Array loader: writes a valid/ready word stream into consecutive register
// file entries, then launches the sort checker and captures its result.
// Optional macro ARRAY_LOADER_INVERSION_HINT_EN adds early_inversion, a
// sticky flag raised when a word is signed-less-than its predecessor.
module array_loader
  import array_pkg::*;
#(
  parameter int DATA_W  = array_pkg::DATA_W,
  parameter int ADDR_W  = array_pkg::ADDR_W,
  parameter int MAX_LEN = array_pkg::MAX_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              go,
  output logic [ADDR_W-1:0] array,
  output logic [ADDR_W-1:0] length,
  input  logic              check_done,
  input  logic              check_sorted,
  output logic              busy,
  output logic              result_valid,
  output logic              result_sorted,
`ifdef ARRAY_LOADER_INVERSION_HINT_EN
  output logic              early_inversion,
`endif
  output logic              error
);

  state_t            state_q, state_d;
  logic              start_ok, accept;
  logic [ADDR_W-1:0] base_q, wr_addr, len;
  logic              ovf;
  logic [ADDR_W-1:0] array_q, len_q;
  logic              result_valid_q, result_sorted_q, error_q;

  array_loader_counter #(
    .ADDR_W  (ADDR_W),
    .MAX_LEN (MAX_LEN)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_ok),
    .incr      (accept),
    .base_i    (base),
    .base_o    (base_q),
    .wr_addr_o (wr_addr),
    .len_o     (len),
    .ovf_o     (ovf)
  );

  // Handshake and write port; reset low blocks a write in the aborting cycle.
  always_comb begin
    start_ok   = start && (state_q == ST_IDLE || state_q == ST_ERR);
    in_ready   = (state_q == ST_LOAD) && reset;
    accept     = in_valid && in_ready;
    rf_wr_en   = accept;
    rf_wr_addr = wr_addr;
    rf_wr_data = in_data;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR: if (start_ok) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (in_last)  state_d = ST_GO;
          else if (ovf) state_d = ST_ERR;
        end
      end
      ST_GO:   state_d = ST_WAIT;
      ST_WAIT: if (check_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, checker hand-off registers, result capture and error flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      array_q         <= '0;
      len_q           <= '0;
      result_valid_q  <= 1'b0;
      result_sorted_q <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_valid_q <= (state_q == ST_WAIT) && check_done;
      if (start_ok) begin
        result_sorted_q <= 1'b0;
        error_q         <= 1'b0;
      end
      if (accept && in_last) begin
        array_q <= base_q;
        len_q   <= len;
      end
      if (accept && !in_last && ovf) error_q <= 1'b1;
      if (state_q == ST_WAIT && check_done) result_sorted_q <= check_sorted;
    end
  end

  always_comb begin
    go            = (state_q == ST_GO);
    busy          = (state_q == ST_LOAD) || (state_q == ST_GO) || (state_q == ST_WAIT);
    array         = array_q;
    length        = len_q;
    result_valid  = result_valid_q;
    result_sorted = result_sorted_q;
    error         = error_q;
  end

`ifdef ARRAY_LOADER_INVERSION_HINT_EN
  logic [DATA_W-1:0] prev_q;
  logic              have_prev_q, inv_q;

  // Track the previous accepted word; the first word of an array has no
  // predecessor, so it can never flag an inversion.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      inv_q       <= 1'b0;
    end else if (start_ok) begin
      have_prev_q <= 1'b0;
      inv_q       <= 1'b0;
    end else if (accept) begin
      prev_q      <= in_data;
      have_prev_q <= 1'b1;
      if (have_prev_q && ($signed(in_data) < $signed(prev_q))) inv_q <= 1'b1;
    end
  end

  assign early_inversion = inv_q;
`endif

endmodule

// File: tb/tb_array_loader.sv
module tb_array_loader;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, check_done, check_sorted;
  logic [4:0]  base;
  logic [31:0] in_data;
  logic        in_ready, rf_wr_en, go, busy, result_valid, result_sorted, error;
  logic [4:0]  rf_wr_addr, array, length;
  logic [31:0] rf_wr_data;
`ifdef ARRAY_LOADER_INVERSION_HINT_EN
  logic        early_inversion;
`endif

  array_loader dut (
    .clock(clock), .reset(reset), .start(start), .base(base),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .go(go), .array(array), .length(length),
    .check_done(check_done), .check_sorted(check_sorted), .busy(busy),
    .result_valid(result_valid), .result_sorted(result_sorted),
`ifdef ARRAY_LOADER_INVERSION_HINT_EN
    .early_inversion(early_inversion),
`endif
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [4:0] a; logic [4:0] l; } go_t;
  wr_t  wq[$];
  go_t  gq[$];
  logic rq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, go or result.
  task automatic monitor();
    logic go_prev = 1'b0;
    wr_t  w;
    go_t  g;
    logic r;
    forever begin
      @(negedge clock);
      if (rf_wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 32'(rf_wr_addr), 32'hFFFF);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(rf_wr_addr), 32'(w.a));
          chk("wr_data", rf_wr_data, w.d);
        end
      end
      if (go) begin
        chk("go_width", 32'(go_prev), 0);
        if (gq.size() == 0) chk("go_unexpected", 32'(go), 0);
        else begin
          g = gq.pop_front();
          chk("go_array", 32'(array), 32'(g.a));
          chk("go_length", 32'(length), 32'(g.l));
        end
      end
      go_prev = go;
      if (result_valid) begin
        if (rq.size() == 0) chk("res_unexpected", 32'(result_valid), 0);
        else begin
          r = rq.pop_front();
          chk("res_sorted", 32'(result_sorted), 32'(r));
        end
      end
    end
  endtask

  task automatic do_start(input logic [4:0] b);
    start = 1'b1;
    base  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic [4:0] a);
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    tick();
  endtask

  task automatic finish_check(input logic s);
    int n = 0;
    while (!go && n < 40) begin
      tick();
      n++;
    end
    if (!go) chk("go_timeout", 32'(go), 1);
    tick();
    rq.push_back(s);
    check_done   = 1'b1;
    check_sorted = s;
    tick();
    check_done   = 1'b0;
    check_sorted = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    go_t g;
    reset = 1'b0; start = 1'b1; base = 5'd7; in_valid = 1'b1; in_data = 32'd99;
    in_last = 1'b1; check_done = 1'b0; check_sorted = 1'b0;
    fork monitor(); join_none

    // reset held two cycles with start and in_valid asserted
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(rf_wr_en), 0);
    chk("rst_go", 32'(go), 0);
    chk("rst_array", 32'(array), 0);
    chk("rst_length", 32'(length), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(result_valid), 0);
    chk("rst_res_sorted", 32'(result_sorted), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();

    // base 11, sorted 1..5
    g.a = 5'd11; g.l = 5'd5; gq.push_back(g);
    do_start(5'd11);
    chk("s1_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) beat(32'(i + 1), i == 4, 5'(11 + i));
    finish_check(1'b1);
    chk("s1_idle_busy", 32'(busy), 0);
    chk("s1_sorted_hold", 32'(result_sorted), 1);
`ifdef ARRAY_LOADER_INVERSION_HINT_EN
    chk("s1_inv", 32'(early_inversion), 0);
`endif

    // base 2, 1,2,3,2,5 with gaps, unsorted
    g.a = 5'd2; g.l = 5'd5; gq.push_back(g);
    do_start(5'd2);
    chk("s2_sorted_cleared", 32'(result_sorted), 0);
    beat(32'd1, 1'b0, 5'd2);
    gap();
    beat(32'd2, 1'b0, 5'd3);
    beat(32'd3, 1'b0, 5'd4);
    gap();
    gap();
`ifdef ARRAY_LOADER_INVERSION_HINT_EN
    chk("s2_inv_before", 32'(early_inversion), 0);
`endif
    beat(32'd2, 1'b0, 5'd5);
`ifdef ARRAY_LOADER_INVERSION_HINT_EN
    chk("s2_inv_after", 32'(early_inversion), 1);
`endif
    gap();
    beat(32'd5, 1'b1, 5'd6);
    finish_check(1'b0);
    chk("s2_sorted", 32'(result_sorted), 0);

    // base 29, no last: overflow at index 31
    do_start(5'd29);
    beat(32'd7, 1'b0, 5'd29);
    beat(32'd8, 1'b0, 5'd30);
    chk("s3_no_err_yet", 32'(error), 0);
    beat(32'd9, 1'b0, 5'd31);
    chk("s3_error", 32'(error), 1);
    chk("s3_in_ready", 32'(in_ready), 0);
    chk("s3_busy", 32'(busy), 0);
    in_valid = 1'b1; in_data = 32'd55;
    tick();
    tick();
    in_valid = 1'b0;
    chk("s3_error_sticky", 32'(error), 1);

    // base 0, 31 beats with last: also clears error
    g.a = 5'd0; g.l = 5'd31; gq.push_back(g);
    do_start(5'd0);
    chk("s4_error_cleared", 32'(error), 0);
    chk("s4_busy", 32'(busy), 1);
`ifdef ARRAY_LOADER_INVERSION_HINT_EN
    chk("s4_inv_cleared", 32'(early_inversion), 0);
`endif
    for (int i = 0; i < 31; i++) beat(32'(100 + i), i == 30, 5'(i));
    finish_check(1'b1);
    chk("s4_error", 32'(error), 0);

    // base 0, 31 beats without last: overflow on beat 31
    do_start(5'd0);
    for (int i = 0; i < 31; i++) begin
      beat(32'(200 + i), 1'b0, 5'(i));
      if (i == 29) chk("s5_no_err_30", 32'(error), 0);
    end
    chk("s5_error", 32'(error), 1);
    chk("s5_in_ready", 32'(in_ready), 0);

    // reset mid-load after two beats
    do_start(5'd5);
    beat(32'd40, 1'b0, 5'd5);
    beat(32'd41, 1'b0, 5'd6);
    reset = 1'b0; in_valid = 1'b1; in_data = 32'd42; in_last = 1'b1;
    tick();
    reset = 1'b1;
    chk("s6_busy", 32'(busy), 0);
    chk("s6_in_ready", 32'(in_ready), 0);
    chk("s6_wr_en", 32'(rf_wr_en), 0);
    chk("s6_array", 32'(array), 0);
    chk("s6_length", 32'(length), 0);
    chk("s6_error", 32'(error), 0);
    in_valid = 1'b0; in_last = 1'b0;
    check_done = 1'b1; check_sorted = 1'b1;
    tick();
    check_done = 1'b0; check_sorted = 1'b0;
    tick();
    chk("s6_no_result", 32'(result_valid), 0);
    chk("s6_sorted", 32'(result_sorted), 0);
    tick();
    tick();

    chk("sb_writes_left", 32'(wq.size()), 0);
    chk("sb_go_left", 32'(gq.size()), 0);
    chk("sb_res_left", 32'(rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
